// File: rtl/apb_split_bridge.sv
// Registered APB bridge: one upstream completer fanned out to G_NUM_PORTS requesters.
// Optional ACCESS-phase timeout enabled by defining APB_SPLIT_BRIDGE_TIMEOUT_EN.
module apb_split_bridge #(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_NUM_PORTS  = 4,
  parameter int G_PORT_LSB   = 12,
  parameter int G_TIMEOUT    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_apb_psel,
  input  logic                              s_apb_penable,
  input  logic                              s_apb_pwrite,
  input  logic [2:0]                        s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]           s_apb_paddr,
  input  logic [G_REGWIDTH-1:0]             s_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]           s_apb_pstrb,
  output logic                              s_apb_pready,
  output logic [G_REGWIDTH-1:0]             s_apb_prdata,
  output logic                              s_apb_pslverr,
  output logic [G_NUM_PORTS-1:0]            m_apb_psel,
  output logic                              m_apb_penable,
  output logic                              m_apb_pwrite,
  output logic [2:0]                        m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]           m_apb_paddr,
  output logic [G_REGWIDTH-1:0]             m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]           m_apb_pstrb,
  input  logic [G_NUM_PORTS-1:0]            m_apb_pready,
  input  logic [G_NUM_PORTS*G_REGWIDTH-1:0] m_apb_prdata,
  input  logic [G_NUM_PORTS-1:0]            m_apb_pslverr
);

  localparam int PW = (G_NUM_PORTS > 1) ? $clog2(G_NUM_PORTS) : 1;
  localparam int SW = G_REGWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                    state_q;
  logic                      s_pready_q;
  logic [G_REGWIDTH-1:0]     s_prdata_q;
  logic                      s_pslverr_q;
  logic [G_NUM_PORTS-1:0]    m_psel_q;
  logic                      m_penable_q;
  logic                      m_pwrite_q;
  logic [2:0]                m_pprot_q;
  logic [G_ADDR_WIDTH-1:0]   m_paddr_q;
  logic [G_REGWIDTH-1:0]     m_pwdata_q;
  logic [SW-1:0]             m_pstrb_q;

  logic [PW-1:0]             up_idx;
  logic                      up_hit;
  logic [G_NUM_PORTS-1:0]    up_sel_d;
  logic                      dn_ready;
  logic                      dn_err;
  logic [G_REGWIDTH-1:0]     dn_rdata;

`ifdef APB_SPLIT_BRIDGE_TIMEOUT_EN
  logic [15:0]               cnt_q;
  logic [15:0]               cnt_d;

  assign cnt_d = cnt_q + 16'd1;
`endif

  // Only the selected port's response is ever looked at.
  always_comb begin
    up_idx   = s_apb_paddr[G_PORT_LSB +: PW];
    up_hit   = ({1'b0, up_idx} < (PW+1)'(G_NUM_PORTS));
    up_sel_d = '0;
    dn_rdata = '0;
    for (int i = 0; i < G_NUM_PORTS; i++) begin
      up_sel_d[i] = (up_idx == PW'(i));
      dn_rdata    = dn_rdata
                  | (m_apb_prdata[i*G_REGWIDTH +: G_REGWIDTH]
                  & {G_REGWIDTH{m_psel_q[i]}});
    end
    dn_ready = |(m_psel_q & m_apb_pready);
    dn_err   = |(m_psel_q & m_apb_pslverr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_pready_q  <= 1'b0;
      s_prdata_q  <= '0;
      s_pslverr_q <= 1'b0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_pprot_q   <= '0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      m_pstrb_q   <= '0;
`ifdef APB_SPLIT_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_apb_psel && s_apb_penable) begin
            if (up_hit) begin
              state_q    <= SETUP;
              m_psel_q   <= up_sel_d;
              m_pwrite_q <= s_apb_pwrite;
              m_pprot_q  <= s_apb_pprot;
              m_paddr_q  <= s_apb_paddr;
              m_pwdata_q <= s_apb_pwdata;
              m_pstrb_q  <= s_apb_pstrb;
`ifdef APB_SPLIT_BRIDGE_TIMEOUT_EN
              cnt_q      <= '0;
`endif
            end else begin
              // Unmapped port: answer locally, nothing goes downstream.
              state_q     <= RESP;
              s_pready_q  <= 1'b1;
              s_prdata_q  <= '0;
              s_pslverr_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q     <= ACCESS;
          m_penable_q <= 1'b1;
        end
        ACCESS: begin
          if (dn_ready) begin
            state_q     <= RESP;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b1;
            s_prdata_q  <= dn_rdata;
            s_pslverr_q <= dn_err;
          end
`ifdef APB_SPLIT_BRIDGE_TIMEOUT_EN
          else begin
            cnt_q <= cnt_d;
            if (cnt_d == 16'(G_TIMEOUT)) begin
              state_q     <= RESP;
              m_psel_q    <= '0;
              m_penable_q <= 1'b0;
              s_pready_q  <= 1'b1;
              s_prdata_q  <= '0;
              s_pslverr_q <= 1'b1;
            end
          end
`endif
        end
        RESP: begin
          state_q     <= IDLE;
          s_pready_q  <= 1'b0;
          s_prdata_q  <= '0;
          s_pslverr_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_apb_pready  = s_pready_q;
  assign s_apb_prdata  = s_prdata_q;
  assign s_apb_pslverr = s_pslverr_q;
  assign m_apb_psel    = m_psel_q;
  assign m_apb_penable = m_penable_q;
  assign m_apb_pwrite  = m_pwrite_q;
  assign m_apb_pprot   = m_pprot_q;
  assign m_apb_paddr   = m_paddr_q;
  assign m_apb_pwdata  = m_pwdata_q;
  assign m_apb_pstrb   = m_pstrb_q;

endmodule

// File: doc/apb_split_bridge.md
# apb_split_bridge

Registered APB bridge that takes one upstream APB completer port and fans it out to `G_NUM_PORTS` downstream requester ports, selected by a field of the address. It is a parametrised successor to the plain APB pass-through. It adds:
- a full register stage between the two sides;
- address decode with error response for unmapped ports;
- PSLVERR propagation;
- an optional access timeout.

It sits between an interconnect APB master and a group of peripheral register blocks.

## Interface
- `G_REGWIDTH`, 32, data width; multiple of 8
- `G_ADDR_WIDTH`, 32, address width
- `G_NUM_PORTS`, 4, downstream port count, 1..16
- `G_PORT_LSB`, 12, LSB of port-select field; field width `PW = max(1, $clog2(G_NUM_PORTS))`
- `G_TIMEOUT`, 256, ACCESS-phase cycle limit (timeout build only), 1..65535
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_apb_psel, s_apb_penable, s_apb_pwrite`  in  1 each  upstream control
- `s_apb_pprot`  in  3  upstream protection
- `s_apb_paddr`  in  G_ADDR_WIDTH  upstream address
- `s_apb_pwdata`  in  G_REGWIDTH  upstream write data
- `s_apb_pstrb`  in  G_REGWIDTH/8  upstream strobes
- `s_apb_pready`  out  1  upstream ready
- `s_apb_prdata`  out  G_REGWIDTH  upstream read data
- `s_apb_pslverr`  out  1  upstream error
- `m_apb_psel`  out  G_NUM_PORTS  one-hot downstream select
- `m_apb_penable, m_apb_pwrite`  out  1 each  shared downstream control
- `m_apb_pprot`  out  3  shared downstream protection
- `m_apb_paddr`  out  G_ADDR_WIDTH  shared downstream address
- `m_apb_pwdata`  out  G_REGWIDTH  shared downstream write data
- `m_apb_pstrb`  out  G_REGWIDTH/8  shared downstream strobes
- `m_apb_pready`  in  G_NUM_PORTS  per-port ready
- `m_apb_prdata`  in  G_NUM_PORTS*G_REGWIDTH  per-port read data, port i at `[i*G_REGWIDTH +: G_REGWIDTH]`
- `m_apb_pslverr`  in  G_NUM_PORTS  per-port error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** on `s_apb_psel & s_apb_penable`, capture:
  - `paddr`, `pwrite`, `pprot`, `pwdata`, `pstrb`;
  - port index `idx = paddr[G_PORT_LSB +: PW]`.
  - If `idx < G_NUM_PORTS`, go to SETUP. Otherwise go to RESP with `pslverr=1`, `prdata=0`, and no downstream activity.
- **SETUP:** `m_apb_psel[idx]=1`, `m_apb_penable=0`; always go to ACCESS next cycle.
- **ACCESS:** `m_apb_psel[idx]=1`, `m_apb_penable=1`; wait for `m_apb_pready[idx]`. When it is seen:
  - capture `m_apb_prdata` slice `idx` (captured for writes too);
  - capture `m_apb_pslverr[idx]`;
  - go to RESP.
- **RESP:** `s_apb_pready=1` for exactly one cycle, with captured `prdata`/`pslverr`; return to IDLE.
- IDLE never re-captures a completed transfer: APB guarantees upstream `penable=0` in the cycle after `pready`.
- Downstream address, control and data outputs are registered copies of the captured values. They hold from SETUP through ACCESS and keep their last value otherwise.
- `m_apb_psel` is all-zero outside SETUP/ACCESS.
- `s_apb_prdata` and `s_apb_pslverr` are 0 whenever `s_apb_pready=0`.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE.
- Reset mid-transfer: at the reset edge `m_apb_psel`, `m_apb_penable` and `s_apb_pready` go to 0 and all captured state clears.
- Latency, upstream ACCESS cycle T0 with zero-wait downstream:
  - T1: SETUP;
  - T2: ACCESS, pready sampled;
  - T3: `s_apb_pready=1`.
  - Total 3 cycles, plus 1 per downstream wait state.
- Decode error: `s_apb_pready=1` at T1, 1-cycle latency.
- Downstream `pready`, `prdata` and `pslverr` of non-selected ports are ignored.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `APB_SPLIT_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - a 16-bit counter clears on SETUP entry and increments each ACCESS cycle without `pready`;
  - when the counter reaches `G_TIMEOUT`, go to RESP with `pslverr=1` and `prdata=0`;
  - `m_apb_psel`/`m_apb_penable` drop at that edge;
  - `pready` in the same cycle the counter reaches the limit wins (normal completion).
- **Undefined:** no counter; ACCESS waits indefinitely; `G_TIMEOUT` is ignored.

## Test plan
- **Zero-wait write:** `G_NUM_PORTS=4`, write `0x0000_2004` data `0xA5A5_1234`, strobe `0xF`.
  - `m_apb_psel=4'b0100`, `paddr=0x2004`, `pwdata=0xA5A5_1234`;
  - `s_apb_pready` 3 cycles after upstream ACCESS, `pslverr=0`.
- **Read with 2 wait states:** port 1 at `0x1010` returns `0xDEAD_BEEF`.
  - `s_apb_prdata=0xDEAD_BEEF` 5 cycles after upstream ACCESS.
- **Decode error:** `G_NUM_PORTS=3`, read `0x3000`.
  - `m_apb_psel` stays 0;
  - 1 cycle later `s_apb_pready=1`, `pslverr=1`, `prdata=0`.
- **Error propagation:** port 0 asserts `pslverr` with `pready` on write to `0x0008` -> upstream `pslverr=1`.
- **Timeout:** timeout build, `G_TIMEOUT=8`, port 3 never ready.
  - ACCESS lasts 8 cycles, then `pslverr=1`, `prdata=0`, `m_apb_psel=0`.
  - Non-timeout build: bridge still waiting after 1000 cycles.
- **Reset in ACCESS:** `rst=1` for 1 cycle during a read to port 2.
  - All outputs 0 next cycle;
  - a following write to `0x0004` completes normally on port 0.
